// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Memory-side responder for the processor data-memory port. A
//            word-organised data RAM sits behind a valid/ready request and
//            response handshake. One load/store is accepted at a time and
//            committed a programmable number of cycles after acceptance.
//            Loads return the whole word; stores honour per-byte strobes.
//            Out-of-range or misaligned addresses return an error response
//            after the normal latency and never touch the RAM.
// Ports    : clk            - clock, all state updates on posedge
//            rstn           - synchronous active-low reset
//            req_valid      - request present
//            req_ready      - responder can accept a request (IDLE)
//            req_write      - 1 = store, 0 = load
//            req_address    - byte address
//            req_write_data - store data, little-endian byte lanes
//            req_strobe     - store byte enables, bit i covers [8i+7:8i]
//            resp_valid     - response present (RESP)
//            resp_ready     - requester accepts the response
//            resp_read_data - load data, 0 for stores and errors
//            resp_error     - address out of range or misaligned
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int unsigned BYTES   = 1024,
    parameter logic [31:0] START   = 32'h1000_8000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    input  logic [3:0]  req_strobe,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_data,
    output logic        resp_error
);

    localparam int unsigned WORDS = BYTES / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [31:0]      c_start    = START;
    localparam logic [31:0]      c_end      = START + BYTES;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              wr_q,     wr_d;
    logic [31:0]       addr_q,   addr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [3:0]        strb_q,   strb_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic              err_q,    err_d;

    logic              w_addr_err;
    logic [IDX_W-1:0]  w_word_idx;
    logic [31:0]       w_ram_rdata;
    logic              w_ram_we;

    // Address decode works on the captured request so the request bus is
    // free to change while the transaction is in flight.
    assign w_addr_err = (addr_q < c_start) || (addr_q >= c_end) || (addr_q[1:0] != 2'b00);
    assign w_word_idx = IDX_W'((addr_q - c_start) >> 2);

    // ------------------------------------------------------------------------
    // Storage: one byte-wide array per lane so each strobe bit owns its lane.
    // Contents are intentionally not reset.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [WORDS];

        always_ff @(posedge clk) begin
            if (w_ram_we && strb_q[i]) begin
                mem[w_word_idx] <= wdata_q[8*i +: 8];
            end
        end

        assign w_ram_rdata[8*i +: 8] = mem[w_word_idx];
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        w_ram_we = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_address;
                    wdata_d = req_write_data;
                    strb_d  = req_strobe;
                    cnt_d   = c_cnt_load;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_one;
                end else begin
                    // Reset wins over commit: a store dropped by reset at this
                    // edge must leave the RAM untouched.
                    w_ram_we = rstn && wr_q && !w_addr_err;
                    rdata_d  = (!wr_q && !w_addr_err) ? w_ram_rdata : 32'h0;
                    err_d    = w_addr_err;
                    state_d  = ST_RESP;
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign resp_read_data = rdata_q;
    assign resp_error     = err_q;

endmodule
`default_nettype wire
